sub_bytes_iter: RTL and testbench

- Iterative AES SubBytes stage that feeds the ShiftRows stage directly.
- Accepts one 128-bit state on a valid/ready handshake and substitutes every byte through SBOX_LANES shared S-box instances, SBOX_LANES bytes per cycle.
- Presents the substituted state on a valid/ready output.
- Trades latency for area: 4 S-boxes instead of 16 by default.

---
 rtl/aes_pkg.sv | 14 +
 rtl/sub_bytes_iter_if.sv | 26 ++
 rtl/aes_sbox.sv | 48 ++++
 rtl/sub_bytes_iter.sv | 112 +++++++++++
 tb/tb_sub_bytes_iter.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES datapath stages.
// Holds the block geometry and the common IDLE/BUSY/DONE sequencer encoding.
package aes_pkg;

  localparam int AES_BLOCK_BITS = 128;
  localparam int AES_BYTE_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } aes_iter_state_e;

endpackage

// File: rtl/sub_bytes_iter_if.sv
// Input/output handshake bundle of the iterative SubBytes stage.
// The slave side is the stage itself; the master side is upstream plus downstream.
interface sub_bytes_iter_if
  import aes_pkg::*;
#(
  parameter int BUS_WIDTH = AES_BLOCK_BITS
);

  logic                 In_Valid;
  logic                 In_Ready;
  logic [BUS_WIDTH-1:0] Data_In;
  logic                 Out_Valid;
  logic                 Out_Ready;
  logic [BUS_WIDTH-1:0] Data_Sub;

  modport slave (
    input  In_Valid, Data_In, Out_Ready,
    output In_Ready, Out_Valid, Data_Sub
  );

  modport master (
    output In_Valid, Data_In, Out_Ready,
    input  In_Ready, Out_Valid, Data_Sub
  );

endinterface

// File: rtl/aes_sbox.sv
// FIPS-197 forward S-box as a purely combinational lookup.
// Shared by the SubBytes lanes and by key expansion.
module aes_sbox (
  input  logic [7:0] raw,
  output logic [7:0] sub
);

  // Table lookup, high nibble selects the row
  always_comb begin
    sub = 8'h00;
    case (raw)
      8'h00: sub = 8'h63; 8'h01: sub = 8'h7c; 8'h02: sub = 8'h77; 8'h03: sub = 8'h7b; 8'h04: sub = 8'hf2; 8'h05: sub = 8'h6b; 8'h06: sub = 8'h6f; 8'h07: sub = 8'hc5;
      8'h08: sub = 8'h30; 8'h09: sub = 8'h01; 8'h0a: sub = 8'h67; 8'h0b: sub = 8'h2b; 8'h0c: sub = 8'hfe; 8'h0d: sub = 8'hd7; 8'h0e: sub = 8'hab; 8'h0f: sub = 8'h76;
      8'h10: sub = 8'hca; 8'h11: sub = 8'h82; 8'h12: sub = 8'hc9; 8'h13: sub = 8'h7d; 8'h14: sub = 8'hfa; 8'h15: sub = 8'h59; 8'h16: sub = 8'h47; 8'h17: sub = 8'hf0;
      8'h18: sub = 8'had; 8'h19: sub = 8'hd4; 8'h1a: sub = 8'ha2; 8'h1b: sub = 8'haf; 8'h1c: sub = 8'h9c; 8'h1d: sub = 8'ha4; 8'h1e: sub = 8'h72; 8'h1f: sub = 8'hc0;
      8'h20: sub = 8'hb7; 8'h21: sub = 8'hfd; 8'h22: sub = 8'h93; 8'h23: sub = 8'h26; 8'h24: sub = 8'h36; 8'h25: sub = 8'h3f; 8'h26: sub = 8'hf7; 8'h27: sub = 8'hcc;
      8'h28: sub = 8'h34; 8'h29: sub = 8'ha5; 8'h2a: sub = 8'he5; 8'h2b: sub = 8'hf1; 8'h2c: sub = 8'h71; 8'h2d: sub = 8'hd8; 8'h2e: sub = 8'h31; 8'h2f: sub = 8'h15;
      8'h30: sub = 8'h04; 8'h31: sub = 8'hc7; 8'h32: sub = 8'h23; 8'h33: sub = 8'hc3; 8'h34: sub = 8'h18; 8'h35: sub = 8'h96; 8'h36: sub = 8'h05; 8'h37: sub = 8'h9a;
      8'h38: sub = 8'h07; 8'h39: sub = 8'h12; 8'h3a: sub = 8'h80; 8'h3b: sub = 8'he2; 8'h3c: sub = 8'heb; 8'h3d: sub = 8'h27; 8'h3e: sub = 8'hb2; 8'h3f: sub = 8'h75;
      8'h40: sub = 8'h09; 8'h41: sub = 8'h83; 8'h42: sub = 8'h2c; 8'h43: sub = 8'h1a; 8'h44: sub = 8'h1b; 8'h45: sub = 8'h6e; 8'h46: sub = 8'h5a; 8'h47: sub = 8'ha0;
      8'h48: sub = 8'h52; 8'h49: sub = 8'h3b; 8'h4a: sub = 8'hd6; 8'h4b: sub = 8'hb3; 8'h4c: sub = 8'h29; 8'h4d: sub = 8'he3; 8'h4e: sub = 8'h2f; 8'h4f: sub = 8'h84;
      8'h50: sub = 8'h53; 8'h51: sub = 8'hd1; 8'h52: sub = 8'h00; 8'h53: sub = 8'hed; 8'h54: sub = 8'h20; 8'h55: sub = 8'hfc; 8'h56: sub = 8'hb1; 8'h57: sub = 8'h5b;
      8'h58: sub = 8'h6a; 8'h59: sub = 8'hcb; 8'h5a: sub = 8'hbe; 8'h5b: sub = 8'h39; 8'h5c: sub = 8'h4a; 8'h5d: sub = 8'h4c; 8'h5e: sub = 8'h58; 8'h5f: sub = 8'hcf;
      8'h60: sub = 8'hd0; 8'h61: sub = 8'hef; 8'h62: sub = 8'haa; 8'h63: sub = 8'hfb; 8'h64: sub = 8'h43; 8'h65: sub = 8'h4d; 8'h66: sub = 8'h33; 8'h67: sub = 8'h85;
      8'h68: sub = 8'h45; 8'h69: sub = 8'hf9; 8'h6a: sub = 8'h02; 8'h6b: sub = 8'h7f; 8'h6c: sub = 8'h50; 8'h6d: sub = 8'h3c; 8'h6e: sub = 8'h9f; 8'h6f: sub = 8'ha8;
      8'h70: sub = 8'h51; 8'h71: sub = 8'ha3; 8'h72: sub = 8'h40; 8'h73: sub = 8'h8f; 8'h74: sub = 8'h92; 8'h75: sub = 8'h9d; 8'h76: sub = 8'h38; 8'h77: sub = 8'hf5;
      8'h78: sub = 8'hbc; 8'h79: sub = 8'hb6; 8'h7a: sub = 8'hda; 8'h7b: sub = 8'h21; 8'h7c: sub = 8'h10; 8'h7d: sub = 8'hff; 8'h7e: sub = 8'hf3; 8'h7f: sub = 8'hd2;
      8'h80: sub = 8'hcd; 8'h81: sub = 8'h0c; 8'h82: sub = 8'h13; 8'h83: sub = 8'hec; 8'h84: sub = 8'h5f; 8'h85: sub = 8'h97; 8'h86: sub = 8'h44; 8'h87: sub = 8'h17;
      8'h88: sub = 8'hc4; 8'h89: sub = 8'ha7; 8'h8a: sub = 8'h7e; 8'h8b: sub = 8'h3d; 8'h8c: sub = 8'h64; 8'h8d: sub = 8'h5d; 8'h8e: sub = 8'h19; 8'h8f: sub = 8'h73;
      8'h90: sub = 8'h60; 8'h91: sub = 8'h81; 8'h92: sub = 8'h4f; 8'h93: sub = 8'hdc; 8'h94: sub = 8'h22; 8'h95: sub = 8'h2a; 8'h96: sub = 8'h90; 8'h97: sub = 8'h88;
      8'h98: sub = 8'h46; 8'h99: sub = 8'hee; 8'h9a: sub = 8'hb8; 8'h9b: sub = 8'h14; 8'h9c: sub = 8'hde; 8'h9d: sub = 8'h5e; 8'h9e: sub = 8'h0b; 8'h9f: sub = 8'hdb;
      8'ha0: sub = 8'he0; 8'ha1: sub = 8'h32; 8'ha2: sub = 8'h3a; 8'ha3: sub = 8'h0a; 8'ha4: sub = 8'h49; 8'ha5: sub = 8'h06; 8'ha6: sub = 8'h24; 8'ha7: sub = 8'h5c;
      8'ha8: sub = 8'hc2; 8'ha9: sub = 8'hd3; 8'haa: sub = 8'hac; 8'hab: sub = 8'h62; 8'hac: sub = 8'h91; 8'had: sub = 8'h95; 8'hae: sub = 8'he4; 8'haf: sub = 8'h79;
      8'hb0: sub = 8'he7; 8'hb1: sub = 8'hc8; 8'hb2: sub = 8'h37; 8'hb3: sub = 8'h6d; 8'hb4: sub = 8'h8d; 8'hb5: sub = 8'hd5; 8'hb6: sub = 8'h4e; 8'hb7: sub = 8'ha9;
      8'hb8: sub = 8'h6c; 8'hb9: sub = 8'h56; 8'hba: sub = 8'hf4; 8'hbb: sub = 8'hea; 8'hbc: sub = 8'h65; 8'hbd: sub = 8'h7a; 8'hbe: sub = 8'hae; 8'hbf: sub = 8'h08;
      8'hc0: sub = 8'hba; 8'hc1: sub = 8'h78; 8'hc2: sub = 8'h25; 8'hc3: sub = 8'h2e; 8'hc4: sub = 8'h1c; 8'hc5: sub = 8'ha6; 8'hc6: sub = 8'hb4; 8'hc7: sub = 8'hc6;
      8'hc8: sub = 8'he8; 8'hc9: sub = 8'hdd; 8'hca: sub = 8'h74; 8'hcb: sub = 8'h1f; 8'hcc: sub = 8'h4b; 8'hcd: sub = 8'hbd; 8'hce: sub = 8'h8b; 8'hcf: sub = 8'h8a;
      8'hd0: sub = 8'h70; 8'hd1: sub = 8'h3e; 8'hd2: sub = 8'hb5; 8'hd3: sub = 8'h66; 8'hd4: sub = 8'h48; 8'hd5: sub = 8'h03; 8'hd6: sub = 8'hf6; 8'hd7: sub = 8'h0e;
      8'hd8: sub = 8'h61; 8'hd9: sub = 8'h35; 8'hda: sub = 8'h57; 8'hdb: sub = 8'hb9; 8'hdc: sub = 8'h86; 8'hdd: sub = 8'hc1; 8'hde: sub = 8'h1d; 8'hdf: sub = 8'h9e;
      8'he0: sub = 8'he1; 8'he1: sub = 8'hf8; 8'he2: sub = 8'h98; 8'he3: sub = 8'h11; 8'he4: sub = 8'h69; 8'he5: sub = 8'hd9; 8'he6: sub = 8'h8e; 8'he7: sub = 8'h94;
      8'he8: sub = 8'h9b; 8'he9: sub = 8'h1e; 8'hea: sub = 8'h87; 8'heb: sub = 8'he9; 8'hec: sub = 8'hce; 8'hed: sub = 8'h55; 8'hee: sub = 8'h28; 8'hef: sub = 8'hdf;
      8'hf0: sub = 8'h8c; 8'hf1: sub = 8'ha1; 8'hf2: sub = 8'h89; 8'hf3: sub = 8'h0d; 8'hf4: sub = 8'hbf; 8'hf5: sub = 8'he6; 8'hf6: sub = 8'h42; 8'hf7: sub = 8'h68;
      8'hf8: sub = 8'h41; 8'hf9: sub = 8'h99; 8'hfa: sub = 8'h2d; 8'hfb: sub = 8'h0f; 8'hfc: sub = 8'hb0; 8'hfd: sub = 8'h54; 8'hfe: sub = 8'hbb; 8'hff: sub = 8'h16;
      default: sub = 8'h00;
    endcase
  end

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: accepts one state, substitutes SBOX_LANES bytes per cycle
// through shared S-boxes, then presents the whole substituted state until taken.
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int BUS_WIDTH  = AES_BLOCK_BITS,
  parameter int SBOX_LANES = 4
) (
  input  logic Clk,
  input  logic Rst,
  sub_bytes_iter_if.slave bus
);

  localparam int N_GRP = (AES_BLOCK_BITS / AES_BYTE_BITS) / SBOX_LANES;
  localparam int GRP_W = (N_GRP > 1) ? $clog2(N_GRP) : 1;
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(N_GRP - 1);
  localparam logic [GRP_W-1:0] GRP_ZERO = GRP_W'(0);
  localparam logic [GRP_W-1:0] GRP_ONE  = GRP_W'(1);

  aes_iter_state_e          state_r, next_state_s;
  logic [GRP_W-1:0]         grp_r, next_grp_s;
  logic [BUS_WIDTH-1:0]     hold_r, next_hold_s;
  logic [BUS_WIDTH-1:0]     data_sub_r, next_data_sub_s;
  logic                     in_ready_r, next_in_ready_s;
  logic                     out_valid_r, next_out_valid_s;
  logic [AES_BYTE_BITS-1:0] lane_raw_s [SBOX_LANES];
  logic [AES_BYTE_BITS-1:0] lane_sub_s [SBOX_LANES];

  // Lane i always serves byte SBOX_LANES*grp+i of the held state
  for (genvar i = 0; i < SBOX_LANES; i++) begin : g_lane
    assign lane_raw_s[i] = hold_r[AES_BYTE_BITS*(SBOX_LANES*int'(grp_r) + i) +: AES_BYTE_BITS];
    aes_sbox u_sbox (
      .raw (lane_raw_s[i]),
      .sub (lane_sub_s[i])
    );
  end

  // Sequencer next-state and next-output decode
  always_comb begin
    next_state_s     = state_r;
    next_grp_s       = grp_r;
    next_hold_s      = hold_r;
    next_data_sub_s  = data_sub_r;
    next_in_ready_s  = in_ready_r;
    next_out_valid_s = out_valid_r;
    case (state_r)
      IDLE: begin
        if (bus.In_Valid && in_ready_r) begin
          next_hold_s     = bus.Data_In;
          next_grp_s      = GRP_ZERO;
          next_in_ready_s = 1'b0;
          next_state_s    = BUSY;
        end else begin
          next_in_ready_s = 1'b1;
        end
      end
      BUSY: begin
        for (int i = 0; i < SBOX_LANES; i++) begin
          next_data_sub_s[AES_BYTE_BITS*(SBOX_LANES*int'(grp_r) + i) +: AES_BYTE_BITS] = lane_sub_s[i];
        end
        // Wrap to zero on the last group so the lane index never leaves the block
        if (grp_r == GRP_LAST) begin
          next_grp_s       = GRP_ZERO;
          next_out_valid_s = 1'b1;
          next_state_s     = DONE;
        end else begin
          next_grp_s       = grp_r + GRP_ONE;
          next_state_s     = BUSY;
        end
      end
      DONE: begin
        if (out_valid_r && bus.Out_Ready) begin
          next_out_valid_s = 1'b0;
          next_in_ready_s  = 1'b1;
          next_state_s     = IDLE;
        end else begin
          next_state_s     = DONE;
        end
      end
      default: begin
        next_state_s     = IDLE;
        next_grp_s       = GRP_ZERO;
        next_in_ready_s  = 1'b0;
        next_out_valid_s = 1'b0;
      end
    endcase
  end

  // State, counter, holding and output registers with asynchronous clear
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r     <= IDLE;
      grp_r       <= GRP_ZERO;
      hold_r      <= {BUS_WIDTH{1'b0}};
      data_sub_r  <= {BUS_WIDTH{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      grp_r       <= next_grp_s;
      hold_r      <= next_hold_s;
      data_sub_r  <= next_data_sub_s;
      in_ready_r  <= next_in_ready_s;
      out_valid_r <= next_out_valid_s;
    end
  end

  assign bus.In_Ready  = in_ready_r;
  assign bus.Out_Valid = out_valid_r;
  assign bus.Data_Sub  = data_sub_r;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: three instances (4, 8, 16 lanes) checked against
// an arithmetic GF(2^8) inverse-plus-affine model of the AES S-box.
module tb_sub_bytes_iter;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0]   in_valid_v  = 3'b000;
  logic [2:0]   out_ready_v = 3'b000;
  logic [127:0] din_v [3];
  logic [2:0]   in_ready_v;
  logic [2:0]   out_valid_v;
  logic [127:0] sub_v [3];

  sub_bytes_iter_if #(.BUS_WIDTH(128)) bus4 ();
  sub_bytes_iter_if #(.BUS_WIDTH(128)) bus8 ();
  sub_bytes_iter_if #(.BUS_WIDTH(128)) bus16 ();

  sub_bytes_iter #(.BUS_WIDTH(128), .SBOX_LANES(4))  dut4  (.Clk(Clk), .Rst(Rst), .bus(bus4));
  sub_bytes_iter #(.BUS_WIDTH(128), .SBOX_LANES(8))  dut8  (.Clk(Clk), .Rst(Rst), .bus(bus8));
  sub_bytes_iter #(.BUS_WIDTH(128), .SBOX_LANES(16)) dut16 (.Clk(Clk), .Rst(Rst), .bus(bus16));

  assign bus4.In_Valid   = in_valid_v[0];
  assign bus8.In_Valid   = in_valid_v[1];
  assign bus16.In_Valid  = in_valid_v[2];
  assign bus4.Out_Ready  = out_ready_v[0];
  assign bus8.Out_Ready  = out_ready_v[1];
  assign bus16.Out_Ready = out_ready_v[2];
  assign bus4.Data_In    = din_v[0];
  assign bus8.Data_In    = din_v[1];
  assign bus16.Data_In   = din_v[2];
  assign in_ready_v  = {bus16.In_Ready, bus8.In_Ready, bus4.In_Ready};
  assign out_valid_v = {bus16.Out_Valid, bus8.Out_Valid, bus4.Out_Valid};
  assign sub_v[0] = bus4.Data_Sub;
  assign sub_v[1] = bus8.Data_Sub;
  assign sub_v[2] = bus16.Data_Sub;

  // Reference model: S(x) = affine(inverse(x)) in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int c = 1; c < 256; c++) begin
      logic [7:0] cb;
      cb = c[7:0];
      if (gmul(a, cb) == 8'h01) inv = cb;
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_state_ref(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox_ref(s[8*k +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One full transaction on the 4-lane instance with Out_Ready held high
  task automatic run_one(input logic [127:0] d, output logic [127:0] res, output int lat, output bit ok);
    ok = 1'b0;
    lat = 0;
    res = 128'h0;
    out_ready_v[0] = 1'b1;
    for (int i = 0; i < 50 && !in_ready_v[0]; i++) tick();
    if (in_ready_v[0]) begin
      in_valid_v[0] = 1'b1;
      din_v[0] = d;
      tick();
      in_valid_v[0] = 1'b0;
      din_v[0] = rand128();
      for (int i = 0; i < 50 && !ok; i++) begin
        tick();
        lat++;
        if (out_valid_v[0]) begin
          ok = 1'b1;
          res = sub_v[0];
        end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid_v  = 3'($urandom());
      out_ready_v = 3'($urandom());
      for (int j = 0; j < 3; j++) din_v[j] = rand128();
      tick();
      n_checks++;
      if ({out_valid_v, in_ready_v} !== 6'b0 || sub_v[0] !== 128'h0 || sub_v[2] !== 128'h0) begin
        n_fail++;
        $display("FAIL reset_outputs: valid=%b ready=%b sub4=%h required all zero", out_valid_v, in_ready_v, sub_v[0]);
      end
    end
    in_valid_v = 3'b000;
    out_ready_v = 3'b000;
    Rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready_v !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release_early: In_Ready=%b required 000", in_ready_v);
    end
    tick();
    n_checks++;
    if (in_ready_v !== 3'b111 || out_valid_v !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_first_edge: In_Ready=%b Out_Valid=%b required 111/000", in_ready_v, out_valid_v);
    end
  endtask

  task automatic test_fips_vector();
    logic [127:0] res;
    int lat;
    bit ok;
    run_one(128'h193de3bea0f4e22b9ac68d2ae9f84808, res, lat, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL fips_timeout: Out_Valid never rose, required rise within 50 cycles");
    end
    n_checks++;
    if (res !== 128'hd42711aee0bf98f1b8b45de51e415230) begin
      n_fail++;
      $display("FAIL fips_data: got %h required d42711aee0bf98f1b8b45de51e415230", res);
    end
    n_checks++;
    if (lat != 4) begin
      n_fail++;
      $display("FAIL fips_latency: got %0d cycles required 4", lat);
    end
  endtask

  task automatic test_byte_map();
    logic [127:0] pats [3];
    logic [127:0] exps [3];
    logic [127:0] res;
    int lat;
    bit ok;
    pats[0] = {16{8'h00}};             exps[0] = {16{8'h63}};
    pats[1] = {16{8'hff}};             exps[1] = {16{8'h16}};
    pats[2] = {8'h53, {15{8'h01}}};    exps[2] = {8'hed, {15{8'h7c}}};
    for (int p = 0; p < 3; p++) begin
      run_one(pats[p], res, lat, ok);
      n_checks++;
      if (!ok || res !== exps[p]) begin
        n_fail++;
        $display("FAIL byte_map_%0d: ok=%0d got %h required %h", p, ok, res, exps[p]);
      end
    end
    for (int p = 0; p < 4; p++) begin
      logic [127:0] d;
      d = rand128();
      run_one(d, res, lat, ok);
      n_checks++;
      if (!ok || res !== sub_state_ref(d) || lat != 4) begin
        n_fail++;
        $display("FAIL random_state_%0d: ok=%0d lat=%0d got %h required %h", p, ok, lat, res, sub_state_ref(d));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] d, exp;
    bit seen;
    d = rand128();
    exp = sub_state_ref(d);
    out_ready_v[0] = 1'b0;
    for (int i = 0; i < 50 && !in_ready_v[0]; i++) tick();
    in_valid_v[0] = 1'b1;
    din_v[0] = d;
    tick();
    in_valid_v[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = out_valid_v[0];
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL backpressure_timeout: Out_Valid never rose, required rise within 20 cycles");
    end
    for (int i = 0; i < 10; i++) begin
      in_valid_v[0] = i[0];
      din_v[0] = rand128();
      tick();
      n_checks++;
      if (out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0 || sub_v[0] !== exp) begin
        n_fail++;
        $display("FAIL backpressure_hold_%0d: valid=%b ready=%b sub=%h required 1/0/%h",
                 i, out_valid_v[0], in_ready_v[0], sub_v[0], exp);
      end
    end
    in_valid_v[0] = 1'b0;
    out_ready_v[0] = 1'b1;
    tick();
    n_checks++;
    if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: valid=%b ready=%b required 0/1", out_valid_v[0], in_ready_v[0]);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid_v[0] || !in_ready_v[0]) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL backpressure_single_transfer: extra activity seen=%0d required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] q [3][$];
    int got [3];
    int acc [3];
    int last [3];
    int lanes [3];
    lanes = '{4, 8, 16};
    for (int j = 0; j < 3; j++) begin
      got[j] = 0;
      acc[j] = 0;
      last[j] = 0;
      out_ready_v[j] = 1'b1;
    end
    for (int cyc = 0; cyc < 300 && (got[0] < 8 || got[1] < 8 || got[2] < 8); cyc++) begin
      for (int j = 0; j < 3; j++) begin
        if (out_valid_v[j]) begin
          n_checks++;
          if (q[j].size() == 0) begin
            n_fail++;
            $display("FAIL b2b_unexpected_%0d: output with nothing accepted, required none", lanes[j]);
          end else begin
            logic [127:0] exp;
            exp = sub_state_ref(q[j].pop_front());
            if (sub_v[j] !== exp) begin
              n_fail++;
              $display("FAIL b2b_data_%0d: got %h required %h", lanes[j], sub_v[j], exp);
            end
          end
          if (got[j] > 0) begin
            n_checks++;
            if (cyc - last[j] != 16 / lanes[j] + 2) begin
              n_fail++;
              $display("FAIL b2b_spacing_%0d: got %0d cycles required %0d", lanes[j], cyc - last[j], 16 / lanes[j] + 2);
            end
          end
          last[j] = cyc;
          got[j]++;
        end
        in_valid_v[j] = (acc[j] < 8);
        din_v[j] = rand128();
        if (in_ready_v[j] && in_valid_v[j]) begin
          q[j].push_back(din_v[j]);
          acc[j]++;
        end
      end
      tick();
    end
    in_valid_v = 3'b000;
    for (int j = 0; j < 3; j++) begin
      n_checks++;
      if (got[j] != 8) begin
        n_fail++;
        $display("FAIL b2b_count_%0d: got %0d outputs required 8", lanes[j], got[j]);
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [127:0] res, d;
    int lat;
    bit ok, seen;
    out_ready_v[0] = 1'b1;
    for (int i = 0; i < 50 && !in_ready_v[0]; i++) tick();
    in_valid_v[0] = 1'b1;
    din_v[0] = rand128();
    tick();
    in_valid_v[0] = 1'b0;
    tick();
    tick();
    Rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b0 || sub_v[0] !== 128'h0) begin
      n_fail++;
      $display("FAIL midbusy_reset_outputs: valid=%b ready=%b sub=%h required all zero",
               out_valid_v[0], in_ready_v[0], sub_v[0]);
    end
    tick();
    tick();
    Rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid_v[0]) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL midbusy_no_output: Out_Valid rose after abort, required never");
    end
    d = rand128();
    run_one(d, res, lat, ok);
    n_checks++;
    if (!ok || res !== sub_state_ref(d) || lat != 4) begin
      n_fail++;
      $display("FAIL midbusy_recover: ok=%0d lat=%0d got %h required %h", ok, lat, res, sub_state_ref(d));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int j = 0; j < 3; j++) din_v[j] = 128'h0;
    test_reset();
    test_fips_vector();
    test_byte_map();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
